// File: rtl/snes_joypad_reader.sv
`default_nettype none
// ============================================================================
//  Module   : snes_joypad_reader
//  Purpose  : Free-running SNES-style serial gamepad reader. It drives the
//             latch/clock waveform on the controller connector, shifts in 16
//             serial bits per frame and presents them as an active-high
//             16-bit button vector in the STE enhanced-joypad layout.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_DIV      clk cycles per half bit period (>= 4)
//    POLL_CYCLES  clk cycles between frame starts (> 35*CLK_DIV)
//  Ports
//    clk          system clock
//    reset        asynchronous active-high reset
//    pad_latch_o  controller latch, active high
//    pad_clk_o    controller shift clock, idles high
//    pad_data_i   controller serial data, asynchronous, low = pressed
//    joy_o        button state, 1 = pressed, [15:12] always 0
//    valid_o      one-cycle strobe when joy_o has been updated
//    connected_o  pad-presence flag
//  Build option
//    SNES_DETECT_EN  when defined, frames whose four ID bits do not read
//                    high are rejected (joy_o cleared, connected_o low).
// ============================================================================
module snes_joypad_reader #(
    parameter int CLK_DIV     = 96,
    parameter int POLL_CYCLES = 32000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pad_latch_o,
    output logic        pad_clk_o,
    input  logic        pad_data_i,
    output logic [15:0] joy_o,
    output logic        valid_o,
    output logic        connected_o
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TMR_W  = $clog2(4 * CLK_DIV);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LATCH_LAST = TMR_W'(4 * CLK_DIV - 1);
    localparam logic [TMR_W-1:0]  HALF_LAST  = TMR_W'(CLK_DIV - 1);
    localparam logic [3:0]        LAST_PULSE = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_q;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [3:0]          pulse_q, pulse_d;
    logic                phase_q, phase_d;     // 0 = pad_clk low half, 1 = high half
    logic [1:0]          sync_q;
    logic [15:0]         sr_q, sr_d;
    logic [15:0]         joy_q, joy_d;
    logic                valid_q;
    logic                conn_q, conn_d;
    logic                latch_q;
    logic                pclk_q;
    logic                w_wrap;
    logic                w_sample;
    logic [15:0]         w_mapped;

    // ------------------------------------------------------------------
    // Two-flop synchronizer on the asynchronous serial data line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_data_i};
        end
    end

    // ------------------------------------------------------------------
    // Free-running poll counter; the wrap to zero launches a frame.
    // ------------------------------------------------------------------
    assign w_wrap = (poll_q == POLL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_q <= '0;
        end else if (w_wrap) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer: next state and sample strobe.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 1'b1;
        pulse_d  = pulse_q;
        phase_d  = phase_q;
        w_sample = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (w_wrap) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (tmr_q == LATCH_LAST) begin
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Sample 0 (B) is already on the line once the latch drops.
                if (tmr_q == HALF_LAST) begin
                    w_sample = 1'b1;
                    tmr_d    = '0;
                    pulse_d  = 4'd1;
                    phase_d  = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of high half: the pad advanced on the rising
                        // edge, so the next bit has been stable for a while.
                        w_sample = 1'b1;
                        phase_d  = 1'b0;
                        if (pulse_q == LAST_PULSE) begin
                            state_d = S_DONE;
                        end else begin
                            pulse_d = pulse_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Samples arrive in serial order and are shifted in from the top, so
    // after 16 samples sample n sits at bit n (stored inverted: 1 = pressed).
    always_comb begin
        sr_d = sr_q;
        if (w_sample) begin
            sr_d = {~sync_q[1], sr_q[15:1]};
        end
    end

    // Serial order B,Y,Sel,Start,U,D,L,R,A,X,L,R reordered to the matrix layout.
    assign w_mapped = {4'b0000,
                       sr_q[11], sr_q[10], sr_q[1], sr_q[9],
                       sr_q[3],  sr_q[2],  sr_q[0], sr_q[8],
                       sr_q[4],  sr_q[5],  sr_q[6], sr_q[7]};

`ifdef SNES_DETECT_EN
    logic w_id_ok;
    // A real pad returns high on all four ID bits, stored as zeros.
    assign w_id_ok = (sr_q[15:12] == 4'b0000);

    always_comb begin
        joy_d  = joy_q;
        conn_d = conn_q;
        if (state_q == S_DONE) begin
            joy_d  = w_id_ok ? w_mapped : 16'h0000;
            conn_d = w_id_ok;
        end
    end
`else
    logic w_unused_id;
    assign w_unused_id = ^sr_q[15:12];

    always_comb begin
        joy_d  = joy_q;
        conn_d = conn_q;
        if (state_q == S_DONE) begin
            joy_d  = w_mapped;
            conn_d = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State and output registers. Pad outputs are registered from the
    // next state so the connector lines never glitch on decode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            pulse_q <= '0;
            phase_q <= 1'b0;
            sr_q    <= '0;
            joy_q   <= '0;
            valid_q <= 1'b0;
            conn_q  <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pulse_q <= pulse_d;
            phase_q <= phase_d;
            sr_q    <= sr_d;
            joy_q   <= joy_d;
            valid_q <= (state_q == S_DONE);
            conn_q  <= conn_d;
            latch_q <= (state_d == S_LATCH);
            pclk_q  <= !((state_d == S_SHIFT) && !phase_d);
        end
    end

    assign pad_latch_o = latch_q;
    assign pad_clk_o   = pclk_q;
    assign joy_o       = joy_q;
    assign valid_o     = valid_q;
    assign connected_o = conn_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_joypad_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snes_joypad_reader
//  Purpose  : Self-checking bench for snes_joypad_reader with a behavioural
//             SNES pad on the connector and a table-driven expected-value
//             model. Honours SNES_DETECT_EN in the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snes_joypad_reader;

    localparam int CLK_DIV     = 4;
    localparam int POLL_CYCLES = 200;
    localparam int FRAME_LEN   = 35 * CLK_DIV;

    logic        clk;
    logic        reset;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data;
    logic [15:0] joy;
    logic        valid;
    logic        connected;

    snes_joypad_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_CYCLES (POLL_CYCLES)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pad_latch_o (pad_latch),
        .pad_clk_o   (pad_clk),
        .pad_data_i  (pad_data),
        .joy_o       (joy),
        .valid_o     (valid),
        .connected_o (connected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_valid = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Pad model: raw serial level for samples 0..15 (1 = high / released).
    // Latch reloads to sample 0; each rising pad_clk advances one sample.
    // ------------------------------------------------------------------
    logic [15:0] pad_bits = 16'hFFFF;
    int          pad_idx  = 16;
    logic        pclk_prev = 1'b1;

    initial pad_data = 1'b1;

    always @(negedge clk) begin
        if (pad_latch) pad_idx = 0;
        else if (pad_clk && !pclk_prev && pad_idx < 16) pad_idx = pad_idx + 1;
        pad_data  = (pad_idx < 16) ? pad_bits[pad_idx] : 1'b1;
        pclk_prev = pad_clk;
    end

    // joy bit k takes serial sample SAMPLE_OF_BIT[k], inverted.
    int SAMPLE_OF_BIT [12] = '{7, 6, 5, 4, 8, 0, 2, 3, 9, 1, 10, 11};

    function automatic logic [15:0] model_joy(input logic [15:0] b);
        logic [15:0] j;
        j = 16'h0000;
        for (int k = 0; k < 12; k++) j[k] = ~b[SAMPLE_OF_BIT[k]];
`ifdef SNES_DETECT_EN
        if (b[15:12] != 4'hF) j = 16'h0000;
`endif
        return j;
    endfunction

    function automatic logic model_conn(input logic [15:0] b);
`ifdef SNES_DETECT_EN
        return (b[15:12] == 4'hF);
`else
        return (b == b);
`endif
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_latch"}, pad_latch, 1'b0);
        check({pfx, "_pclk"},  pad_clk,   1'b1);
        check({pfx, "_joy"},   joy,       16'h0000);
        check({pfx, "_valid"}, valid,     1'b0);
        check({pfx, "_conn"},  connected, 1'b0);
    endtask

    // One full frame: waits for latch, optionally checks the waveform,
    // then checks the result presented with valid.
    task automatic frame(input logic [15:0] bits, input bit detail);
        int   n, t, lat, falls, lows, bad_gap, first_fall, last_fall;
        logic prev_clk;
        pad_bits = bits;
        n = 0;
        while (!pad_latch && n < 2 * POLL_CYCLES) begin @(negedge clk); n++; end
        if (!pad_latch) begin check("latch_timeout", 0, 1); return; end
        t = 0; lat = 0; falls = 0; lows = 0; bad_gap = 0;
        first_fall = -1; last_fall = -1; prev_clk = 1'b1;
        while (!valid && t < 2 * POLL_CYCLES) begin
            if (pad_latch) lat++;
            if (!pad_clk) lows++;
            if (!pad_clk && prev_clk) begin
                if (falls == 0) first_fall = t;
                else if (t - last_fall != 2 * CLK_DIV) bad_gap++;
                last_fall = t;
                falls++;
            end
            prev_clk = pad_clk;
            @(negedge clk); t++;
        end
        if (!valid) begin check("valid_timeout", 0, 1); return; end
        if (detail) begin
            check("latch_width", lat, 4 * CLK_DIV);
            check("clk_pulses",  falls, 15);
            check("first_fall",  first_fall, 5 * CLK_DIV);
            check("clk_period",  bad_gap, 0);
            check("clk_low_sum", lows, 15 * CLK_DIV);
            check("valid_at",    t, FRAME_LEN + 1);
        end
        check("joy",  joy, model_joy(bits));
        check("conn", connected, model_conn(bits));
        if (last_valid >= 0) check("valid_spacing", cyc - last_valid, POLL_CYCLES);
        last_valid = cyc;
        @(negedge clk);
        check("valid_width", valid, 1'b0);
    endtask

    initial begin
        int          n;
        logic [15:0] b;
        logic        prev_clk;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // First latch rise exactly POLL_CYCLES after release.
        n = 0;
        while (!pad_latch && n < 2 * POLL_CYCLES) begin @(negedge clk); n++; end
        check("first_latch", n, POLL_CYCLES);

        // Mapping frame with full waveform check: Start and Right pressed.
        frame(16'hFF77, 1'b1);
        check("map_0081", joy, 16'h0081);

        // Randomized frames, half with a valid ID nibble.
        for (int i = 0; i < 8; i++) begin
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) b[15:12] = 4'hF;
            frame(b, (i == 3));
        end

        // All buttons pressed, then all released.
        frame(16'hF000, 1'b0);
        frame(16'hFFFF, 1'b0);

        // Data line tied low (no pad), then a valid pad again.
        frame(16'h0000, 1'b0);
        frame(16'hF5A5, 1'b0);

        // Mid-frame reset during SHIFT pulse 6.
        frame(16'hFF77, 1'b0);
        pad_bits = 16'hF3C9;
        n = 0;
        while (!pad_latch && n < 2 * POLL_CYCLES) begin @(negedge clk); n++; end
        n = 0; prev_clk = 1'b1;
        while (n < 6 && pad_latch !== 1'bx) begin
            @(negedge clk);
            if (!pad_clk && prev_clk) n++;
            prev_clk = pad_clk;
            if (cyc - last_valid > 2 * POLL_CYCLES) break;
        end
        check("pulse6_reached", n, 6);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!valid && n < 3 * POLL_CYCLES) begin @(negedge clk); n++; end
        check("post_rst_valid", n, POLL_CYCLES + FRAME_LEN + 1);
        check("post_rst_joy", joy, model_joy(pad_bits));
        check("post_rst_conn", connected, model_conn(pad_bits));
        last_valid = cyc;

        frame(16'hFFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
